sysmgr_pll_ctrl: RTL and testbench

//  Sequencer for the iCE40 PLL clock/reset manager. Runs on the free-running reference clock.
//  - Holds the PLL in reset, waits for LOCK with a timeout, then filters LOCK for stability.
//  - Releases the system reset request; re-sequences on lock loss or software restart.
//  - Sits between board reset/control logic and the PLL RESETB/LOCK pins.

---
 rtl/sysmgr_pll_ctrl.sv | 125 ++++++++++++
 tb/tb_sysmgr_pll_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysmgr_pll_ctrl.sv
// rtl/sysmgr_pll_ctrl.sv - iCE40 PLL reset/lock sequencer running on the free-running reference clock
// Optional retry limit with terminal FAIL state: define SYSMGR_RETRY_LIMIT_EN.
module sysmgr_pll_ctrl #(
    parameter int HOLD_CYCLES  = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 256,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt
);

    localparam int MAX_A = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [3:0]    RETRY_LAST   = 4'(MAX_RETRY - 1);

`ifdef SYSMGR_RETRY_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          lock_m;
    logic          lock_s;
    logic          retry_inc;

    // pll_lock is asynchronous to clk
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_HOLD;
            cnt       <= '0;
            retry_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (restart || (state_next != state)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (restart) begin
                retry_cnt <= 4'd0;
            end else if (retry_inc && (retry_cnt != 4'hf)) begin
                retry_cnt <= retry_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        retry_inc  = 1'b0;
        case (state)
            S_HOLD: begin
                if (cnt == HOLD_LAST) state_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_inc  = 1'b1;
                    state_next = (LIMIT_EN && (retry_cnt == RETRY_LAST)) ? S_FAIL : S_HOLD;
                end
            end
            S_STABLE: begin
                // a lock drop restarts the timeout window but is not a failed attempt
                if (!lock_s) begin
                    state_next = S_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_s) state_next = S_HOLD;
            end
            S_FAIL: begin
                state_next = S_FAIL;
            end
            default: begin
                state_next = S_HOLD;
            end
        endcase
        if (restart) begin
            state_next = S_HOLD;
            retry_inc  = 1'b0;
        end
    end

    assign pll_rst = (state == S_HOLD) || (state == S_FAIL);
    assign sys_rst = (state != S_RUN);
    assign ready   = (state == S_RUN);
    assign fail    = LIMIT_EN && (state == S_FAIL);

endmodule

// File: tb/tb_sysmgr_pll_ctrl.sv
// tb/tb_sysmgr_pll_ctrl.sv - scoreboard bench for sysmgr_pll_ctrl with event-time reference model
module tb_sysmgr_pll_ctrl;

    localparam int HOLD = 4;
    localparam int TOUT = 32;
    localparam int STAB = 8;
    localparam int MAXR = 3;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;

    sysmgr_pll_ctrl #(
        .HOLD_CYCLES (HOLD),
        .LOCK_TIMEOUT(TOUT),
        .LOCK_STABLE (STAB),
        .MAX_RETRY   (MAXR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pll_lock (pll_lock),
        .restart  (restart),
        .pll_rst  (pll_rst),
        .sys_rst  (sys_rst),
        .ready    (ready),
        .fail     (fail),
        .retry_cnt(retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         edge_n;
        logic [7:0] vec;
    } ev_t;

    ev_t  exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    logic [7:0] prev_v;
    logic [7:0] cur_v;
    ev_t  mon_e;

    // Expected output changes: {pll_rst, sys_rst, ready, fail, retry_cnt}
    function automatic logic [7:0] ov(input logic pr, input logic sr, input logic rd,
                                      input logic fl, input logic [3:0] rc);
        return {pr, sr, rd, fl, rc};
    endfunction

    task automatic push(input int e, input logic [7:0] v);
        ev_t x;
        x.edge_n = e;
        x.vec    = v;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cur_v = {pll_rst, sys_rst, ready, fail, retry_cnt};
            while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event: expected %b at edge %0d, still %b at edge %0d",
                         mon_e.vec, mon_e.edge_n, cur_v, cyc);
            end
            if (cur_v !== prev_v) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %b at edge %0d, required %b (no change)",
                             cur_v, cyc, prev_v);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.edge_n != cyc || mon_e.vec !== cur_v) begin
                        errors++;
                        $display("FAIL output_event: got %b at edge %0d, required %b at edge %0d",
                                 cur_v, cyc, mon_e.vec, mon_e.edge_n);
                    end
                end
                prev_v = cur_v;
            end
        end
    end

    int t_hold;
    int r;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    // From HOLD entered at t_hold: lock rises n cycles after pll_rst falls
    task automatic lock_seq(input int n);
        int fall;
        fall = t_hold + HOLD;
        push(fall, ov(1'b0, 1'b1, 1'b0, 1'b0, 4'(r)));
        push(fall + n + 3 + STAB, ov(1'b0, 1'b0, 1'b1, 1'b0, 4'(r)));
        goto(fall + n);
        pll_lock = 1'b1;
        goto(fall + n + 3 + STAB);
    endtask

    task automatic drop_in_run();
        int d;
        d = cyc + int'($urandom_range(0, 10));
        goto(d);
        pll_lock = 1'b0;
        push(d + 3, ov(1'b1, 1'b1, 1'b0, 1'b0, 4'(r)));
        t_hold = d + 3;
        goto(t_hold);
    endtask

    // Lock reaches STABLE, then drops for len cycles starting off cycles into STABLE
    task automatic glitch_stable(input int n, input int len, input int off);
        int fall;
        int g;
        fall = t_hold + HOLD;
        g    = fall + n + 3 + off;
        push(fall, ov(1'b0, 1'b1, 1'b0, 1'b0, 4'(r)));
        push(g + len + 3 + STAB, ov(1'b0, 1'b0, 1'b1, 1'b0, 4'(r)));
        goto(fall + n);
        pll_lock = 1'b1;
        goto(g);
        pll_lock = 1'b0;
        goto(g + len);
        pll_lock = 1'b1;
        goto(g + len + 3 + STAB);
    endtask

    // k consecutive lock timeouts with pll_lock held low; returns 1 if FAIL was entered
    task automatic timeouts(input int k, output bit failed);
        int fall;
        int rn;
        failed = 1'b0;
        for (int i = 0; i < k; i++) begin
            fall = t_hold + HOLD;
            push(fall, ov(1'b0, 1'b1, 1'b0, 1'b0, 4'(r)));
            rn = (r < 15) ? r + 1 : 15;
`ifdef SYSMGR_RETRY_LIMIT_EN
            if (rn == MAXR) begin
                push(fall + TOUT, ov(1'b1, 1'b1, 1'b0, 1'b1, 4'(rn)));
                r = rn;
                failed = 1'b1;
                goto(fall + TOUT);
                return;
            end
`endif
            push(fall + TOUT, ov(1'b1, 1'b1, 1'b0, 1'b0, 4'(rn)));
            r = rn;
            t_hold = fall + TOUT;
            goto(t_hold);
        end
    endtask

    task automatic do_restart(input int x, input int h);
        goto(x);
        push(x + 1, ov(1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
        restart = 1'b1;
        goto(x + h);
        restart = 1'b0;
        r = 0;
        t_hold = x + h;
    endtask

    task automatic restart_in_wait();
        int fall;
        fall = t_hold + HOLD;
        push(fall, ov(1'b0, 1'b1, 1'b0, 1'b0, 4'(r)));
        do_restart(fall + int'($urandom_range(0, 30)), int'($urandom_range(1, 3)));
    endtask

    // One-cycle rst while in RUN with pll_lock still high
    task automatic reset_in_run();
        int x;
        x = cyc + int'($urandom_range(0, 5));
        goto(x);
        rst = 1'b1;
        push(x + 1, ov(1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
        step();
        rst = 1'b0;
        r = 0;
        t_hold = x + 1;
        push(t_hold + HOLD, ov(1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
        push(t_hold + HOLD + 1 + STAB, ov(1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
        goto(t_hold + HOLD + 1 + STAB);
    endtask

    initial begin
        bit failed;
        rst      = 1'b1;
        pll_lock = 1'b0;
        restart  = 1'b0;
        step();
        step();
        step();
        rst = 1'b0;
        t_hold = cyc;
        r = 0;
        checks++;
        if ({pll_rst, sys_rst, ready, fail, retry_cnt} !== ov(1'b1, 1'b1, 1'b0, 1'b0, 4'd0)) begin
            errors++;
            $display("FAIL reset_values: got %b, required %b",
                     {pll_rst, sys_rst, ready, fail, retry_cnt}, ov(1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
        end
        prev_v = ov(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        mon_en = 1'b1;

        lock_seq(5);
        drop_in_run();
        lock_seq(int'($urandom_range(0, 20)));
        drop_in_run();
        glitch_stable(int'($urandom_range(0, 10)), int'($urandom_range(1, 4)), 5);
        drop_in_run();
        timeouts(2, failed);
        restart_in_wait();
        lock_seq(int'($urandom_range(0, 20)));
        reset_in_run();

        for (int i = 0; i < 6; i++) begin
            drop_in_run();
            if ($urandom_range(0, 1) == 1)
                lock_seq(int'($urandom_range(0, 29)));
            else
                glitch_stable(int'($urandom_range(0, 20)), int'($urandom_range(1, 4)),
                              int'($urandom_range(0, 5)));
        end

        drop_in_run();
`ifdef SYSMGR_RETRY_LIMIT_EN
        timeouts(MAXR, failed);
        goto(cyc + 20);
        do_restart(cyc, 1);
`else
        timeouts(16, failed);
        restart_in_wait();
`endif
        lock_seq(int'($urandom_range(0, 20)));
        goto(cyc + 10);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d unseen events, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
